// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: cache miss handler between a cache and pipelined main memory.
// On a miss it issues one read per word of the block, back-to-back, streams
// each returned word into the data array, then pulses a single tag write.
// Optional build macro CACHE_FILL_CWF_EN enables critical-word-first ordering:
// requests and data-array writes start at the missed word and wrap around.
module cache_fill_fsm #(
    parameter int WORDS_PER_BLOCK = 8,
    parameter int ADDR_W          = 16,
    localparam int IDX_W          = $clog2(WORDS_PER_BLOCK)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    output logic              fsm_busy,
    output logic              mem_req,
    output logic [ADDR_W-1:0] memory_address,
    input  logic              memory_data_valid,
    input  logic [15:0]       memory_data,
    output logic              write_data_array,
    output logic [IDX_W-1:0]  data_array_word,
    output logic [15:0]       data_array_data,
    output logic              write_tag_array,
    output logic [ADDR_W-1:0] fill_address
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [IDX_W:0]   CNT_FULL = (IDX_W+1)'(WORDS_PER_BLOCK);
    localparam logic [IDX_W:0]   CNT_LAST = (IDX_W+1)'(WORDS_PER_BLOCK - 1);
    localparam logic [IDX_W:0]   CNT_ONE  = (IDX_W+1)'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS_PER_BLOCK - 1);
    // Block offset covers word index plus the byte-in-word bit.
    localparam logic [ADDR_W-1:0] BLK_MASK = ADDR_W'(2 * WORDS_PER_BLOCK - 1);

    logic [1:0]        r_state;
    logic [IDX_W:0]    r_req_cnt;
    logic [IDX_W:0]    r_rcv_cnt;
    logic [ADDR_W-1:0] r_fill_addr;
    logic [IDX_W-1:0]  r_start;

    logic [ADDR_W-1:0] w_base;
    logic [IDX_W-1:0]  w_start;
    logic              w_req_active;
    logic              w_rcv;
    logic [IDX_W-1:0]  w_req_idx;
    logic [IDX_W-1:0]  w_req_word;
    logic [IDX_W-1:0]  w_rcv_word;

    assign w_base = miss_address & ~BLK_MASK;

`ifdef CACHE_FILL_CWF_EN
    assign w_start = miss_address[IDX_W:1];
`else
    assign w_start = '0;
`endif

    // Counters saturate at a full block; the MSB alone marks saturation
    // because the block size is a power of two.
    assign w_req_active = (r_state == S_FILL) && (r_req_cnt != CNT_FULL);
    assign w_rcv        = (r_state == S_FILL) && memory_data_valid && (r_rcv_cnt != CNT_FULL);

    // Once all requests are out, keep pointing at the last requested word so
    // memory_address holds its final value.
    assign w_req_idx  = r_req_cnt[IDX_W] ? IDX_LAST : r_req_cnt[IDX_W-1:0];
    assign w_req_word = r_start + w_req_idx;
    assign w_rcv_word = r_start + r_rcv_cnt[IDX_W-1:0];

    assign fsm_busy         = (r_state != S_IDLE);
    assign mem_req          = w_req_active;
    assign memory_address   = r_fill_addr + ADDR_W'({w_req_word, 1'b0});
    assign write_data_array = w_rcv;
    assign data_array_word  = w_rcv ? w_rcv_word : '0;
    assign data_array_data  = memory_data;
    assign write_tag_array  = (r_state == S_DONE);
    assign fill_address     = r_fill_addr;

    // Miss FSM with independent request and receive counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_req_cnt   <= '0;
            r_rcv_cnt   <= '0;
            r_fill_addr <= '0;
            r_start     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (miss_detected) begin
                        r_state     <= S_FILL;
                        r_fill_addr <= w_base;
                        r_start     <= w_start;
                        r_req_cnt   <= '0;
                        r_rcv_cnt   <= '0;
                    end
                end
                S_FILL: begin
                    if (w_req_active)
                        r_req_cnt <= r_req_cnt + CNT_ONE;
                    if (w_rcv) begin
                        r_rcv_cnt <= r_rcv_cnt + CNT_ONE;
                        if (r_rcv_cnt == CNT_LAST)
                            r_state <= S_DONE;
                    end
                end
                S_DONE: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm: directed + randomized fills against a pipelined memory
// model; expected request/write sequences derived from the miss address.
module tb_cache_fill_fsm;

    localparam int W = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        miss_detected = 1'b0;
    logic [15:0] miss_address = '0;
    logic        fsm_busy;
    logic        mem_req;
    logic [15:0] memory_address;
    logic        memory_data_valid = 1'b0;
    logic [15:0] memory_data = '0;
    logic        write_data_array;
    logic [2:0]  data_array_word;
    logic [15:0] data_array_data;
    logic        write_tag_array;
    logic [15:0] fill_address;

    int checks = 0;
    int errors = 0;

    cache_fill_fsm dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .fsm_busy          (fsm_busy),
        .mem_req           (mem_req),
        .memory_address    (memory_address),
        .memory_data_valid (memory_data_valid),
        .memory_data       (memory_data),
        .write_data_array  (write_data_array),
        .data_array_word   (data_array_word),
        .data_array_data   (data_array_data),
        .write_tag_array   (write_tag_array),
        .fill_address      (fill_address)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One complete miss: drive the miss, act as a pipelined memory with
    // latency lat and at least gap idle cycles between returned words, then
    // compare the observed traffic with what the miss address implies.
    // Entered and left in the low clock phase; on return the DUT is in its
    // first IDLE cycle.
    task automatic do_fill(input logic [15:0] ma, input int lat, input int gap,
                           input bit extra, input logic [15:0] dbase);
        logic [15:0] req_addr_q[$];
        int          req_cyc_q[$];
        int          due_q[$];
        logic [2:0]  wr_word_q[$];
        logic [15:0] wr_data_q[$];
        logic [15:0] base;
        int start, cyc, last_sched, last_ret, nret, tag_cnt, tag_cyc;
        bit extra_done;

        base = ma & 16'hFFF0;
`ifdef CACHE_FILL_CWF_EN
        start = int'(ma[3:1]);
`else
        start = 0;
`endif
        miss_detected     = 1'b1;
        miss_address      = ma;
        memory_data_valid = 1'b0;
        #1 chk("busy_at_miss", fsm_busy, 0);
        @(posedge clk);
        #1;
        miss_detected = 1'b0;
        miss_address  = 16'($urandom);

        cyc = 0; last_sched = -100; last_ret = -100; nret = 0;
        tag_cnt = 0; tag_cyc = -1; extra_done = 0;
        while (cyc < 400) begin
            @(negedge clk);
            cyc++;
            memory_data_valid = 1'b0;
            if (tag_cnt > 0 && cyc == tag_cyc + 1) break;
            if (due_q.size() > 0 && due_q[0] <= cyc) begin
                void'(due_q.pop_front());
                memory_data_valid = 1'b1;
                memory_data       = dbase + 16'(nret);
                nret++;
                last_ret = cyc;
            end else if (extra && !extra_done && nret == W) begin
                memory_data_valid = 1'b1;
                memory_data       = 16'hDEAD;
                extra_done        = 1;
            end
            #1;
            if (mem_req) begin
                req_addr_q.push_back(memory_address);
                req_cyc_q.push_back(cyc);
                last_sched = (cyc + lat > last_sched + 1 + gap) ? cyc + lat : last_sched + 1 + gap;
                due_q.push_back(last_sched);
            end
            if (write_data_array) begin
                wr_word_q.push_back(data_array_word);
                wr_data_q.push_back(data_array_data);
            end
            if (write_tag_array) begin
                tag_cnt++;
                tag_cyc = cyc;
                chk("tag_fill_addr", fill_address, base);
            end
            chk("busy_fill", fsm_busy, 1);
        end

        chk("req_count", req_addr_q.size(), W);
        for (int i = 0; i < W && i < req_addr_q.size(); i++) begin
            chk("req_addr", req_addr_q[i], base + 16'(2 * ((start + i) % W)));
            chk("req_cycle", req_cyc_q[i], i + 1);
        end
        chk("wr_count", wr_word_q.size(), W);
        for (int i = 0; i < W && i < wr_word_q.size(); i++) begin
            chk("wr_word", wr_word_q[i], (start + i) % W);
            chk("wr_data", wr_data_q[i], dbase + 16'(i));
        end
        chk("tag_count", tag_cnt, 1);
        chk("tag_cycle", tag_cyc, last_ret + 1);
        if (gap == 0) chk("tag_latency", tag_cyc, 9 + lat);
    endtask

    initial begin
        // Reset state, observed while rst is held.
        #1;
        chk("rst_busy", fsm_busy, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", memory_address, 0);
        chk("rst_wr", write_data_array, 0);
        chk("rst_word", data_array_word, 0);
        chk("rst_tag", write_tag_array, 0);
        chk("rst_fill_addr", fill_address, 0);
        @(negedge clk);
        rst = 1'b0;

        // Valid while idle must not write.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            memory_data_valid = 1'b1;
            memory_data       = 16'hBEEF;
            #1;
            chk("idle_valid_wr", write_data_array, 0);
            chk("idle_busy", fsm_busy, 0);
        end
        @(negedge clk);
        memory_data_valid = 1'b0;

        // Basic fill.
        do_fill(16'h1234, 4, 0, 1'b0, 16'hA000);
        // Ninth valid during the fill is ignored.
        do_fill(16'h5678, 3, 0, 1'b1, 16'h3100);

        // Asynchronous reset in the middle of cycle 7 of a fill.
        miss_detected     = 1'b1;
        miss_address      = 16'h1234;
        @(posedge clk);
        #1;
        miss_detected     = 1'b0;
        memory_data_valid = 1'b1;
        memory_data       = 16'h7777;
        repeat (6) @(posedge clk);
        #1;
        chk("pre_rst_req", mem_req, 1);
        chk("pre_rst_wr", write_data_array, 1);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_busy", fsm_busy, 0);
        chk("mid_rst_req", mem_req, 0);
        chk("mid_rst_wr", write_data_array, 0);
        chk("mid_rst_tag", write_tag_array, 0);
        chk("mid_rst_addr", memory_address, 0);
        chk("mid_rst_word", data_array_word, 0);
        chk("mid_rst_fill_addr", fill_address, 0);
        memory_data_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("post_rst_tag", write_tag_array, 0);
            chk("post_rst_busy", fsm_busy, 0);
        end
        do_fill(16'h0040, 4, 0, 1'b0, 16'h4000);

        // Back-to-back misses, second accepted in the first IDLE cycle; wrap.
        do_fill(16'hFFF6, 2, 0, 1'b0, 16'h5000);
        do_fill(16'h0002, 5, 0, 1'b0, 16'h6000);

        // Slow memory with gaps between words.
        do_fill(16'h2468, 10, 2, 1'b0, 16'h7000);

        // Randomized fills.
        for (int n = 0; n < 10; n++) begin
            do_fill(16'($urandom), int'($urandom_range(1, 12)), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 16'($urandom));
        end

        @(negedge clk);
        #1 chk("final_busy", fsm_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
